frog_bank: RTL and testbench

//   Multi-channel, run-time-programmable LFSR bank; next generation of the single-channel frog generator.
//   C independent N-bit LFSRs, each with its own tap mask and seed, loaded over one shared serial config port.

---
 rtl/frog_bank_if.sv | 31 +++
 rtl/frog_bank.sv | 136 +++++++++++++
 tb/tb_frog_bank.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frog_bank_if.sv
// Bundled config, run and readback signals for frog_bank.
// master drives the config/run/readback inputs; slave is the bank itself.
interface frog_bank_if #(
  parameter int N = 16,
  parameter int C = 4
);
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  logic          cfg_start;
  logic [CW-1:0] cfg_ch;
  logic          cfg_bit_valid;
  logic          cfg_bit;
  logic          cfg_busy;
  logic          cfg_err;
  logic          run_en;
  logic [C-1:0]  out;
  logic [C-1:0]  lockup;
  logic [CW-1:0] rd_ch;
  logic [N-1:0]  rd_lfsr;
  logic [N-1:0]  rd_taps;

  modport master (
    output cfg_start, cfg_ch, cfg_bit_valid, cfg_bit, run_en, rd_ch,
    input  cfg_busy, cfg_err, out, lockup, rd_lfsr, rd_taps
  );

  modport slave (
    input  cfg_start, cfg_ch, cfg_bit_valid, cfg_bit, run_en, rd_ch,
    output cfg_busy, cfg_err, out, lockup, rd_lfsr, rd_taps
  );
endinterface

// File: rtl/frog_bank.sv
// Multi-channel programmable LFSR bank with serial tap/seed loading and sticky lockup flags.
// Define LOCKUP_RECOVER_EN to make an all-zero channel reload 1 when it steps.
module frog_bank #(
  parameter int N      = 16,
  parameter int C      = 4,
  parameter bit GALOIS = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  frog_bank_if.slave  bus
);
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int KW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  lfsr_q [C];
  logic [N-1:0]  lfsr_d [C];
  logic [N-1:0]  taps_q [C];
  logic [N-1:0]  taps_d [C];
  logic [CW-1:0] ch_q, ch_d;
  logic [KW-1:0] k_q, k_d;
  logic [C-1:0]  lockup_q, lockup_d;
  logic          cfg_err_q, cfg_err_d;
  logic          busy_q, busy_d;
  logic          start_ok;

  function automatic logic [N-1:0] step_fn(input logic [N-1:0] s, input logic [N-1:0] t);
    logic [N-1:0] r;
    if (GALOIS) r = (s >> 1) ^ (s[0] ? t : '0);
    else        r = {^(s & t), s[N-1:1]};
`ifdef LOCKUP_RECOVER_EN
    if (s == '0) r = {{(N-1){1'b0}}, 1'b1};
`endif
    return r;
  endfunction

  assign start_ok = bus.cfg_start && (int'(bus.cfg_ch) < C);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    k_d       = k_q;
    lockup_d  = lockup_q;
    cfg_err_d = 1'b0;
    for (int unsigned c = 0; c < C; c++) begin
      lfsr_d[c] = lfsr_q[c];
      taps_d[c] = taps_q[c];
    end

    case (state_q)
      IDLE, RUN: begin
        // A rejected cfg_start still pre-empts run_en: no step, state kept.
        if (bus.cfg_start) begin
          if (start_ok) begin
            state_d = LOAD;
            ch_d    = bus.cfg_ch;
            k_d     = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else if (bus.run_en) begin
          state_d = RUN;
          if (state_q == RUN) begin
            for (int unsigned c = 0; c < C; c++) begin
              if (lfsr_q[c] == '0) lockup_d[c] = 1'b1;
              lfsr_d[c] = step_fn(lfsr_q[c], taps_q[c]);
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (bus.cfg_bit_valid) begin
          if (int'(k_q) < N) taps_d[ch_q] = {bus.cfg_bit, taps_q[ch_q][N-1:1]};
          else               lfsr_d[ch_q] = {bus.cfg_bit, lfsr_q[ch_q][N-1:1]};
          if (int'(k_q) == 2 * N - 1) begin
            state_d          = IDLE;
            lockup_d[ch_q]   = 1'b0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      k_q       <= '0;
      lockup_q  <= '0;
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int unsigned c = 0; c < C; c++) begin
        lfsr_q[c] <= '0;
        taps_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      k_q       <= k_d;
      lockup_q  <= lockup_d;
      cfg_err_q <= cfg_err_d;
      busy_q    <= busy_d;
      for (int unsigned c = 0; c < C; c++) begin
        lfsr_q[c] <= lfsr_d[c];
        taps_q[c] <= taps_d[c];
      end
    end
  end

  assign bus.cfg_busy = busy_q;
  assign bus.cfg_err  = cfg_err_q;
  assign bus.lockup   = lockup_q;

  always_comb begin
    bus.out = '0;
    for (int unsigned c = 0; c < C; c++) bus.out[c] = lfsr_q[c][0];
  end

  always_comb begin
    bus.rd_lfsr = '0;
    bus.rd_taps = '0;
    if (int'(bus.rd_ch) < C) begin
      bus.rd_lfsr = lfsr_q[bus.rd_ch];
      bus.rd_taps = taps_q[bus.rd_ch];
    end
  end
endmodule

// File: tb/tb_frog_bank.sv
// Directed bench for frog_bank: Fibonacci (C=4), Galois (C=4) and C=3 instances.
// Table-driven load/run vectors plus hand-written multi-cycle corner sequences.
module tb_frog_bank;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  frog_bank_if #(.N(4), .C(4)) ifa ();
  frog_bank_if #(.N(4), .C(4)) ifg ();
  frog_bank_if #(.N(4), .C(3)) ifc ();

  frog_bank #(.N(4), .C(4), .GALOIS(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  frog_bank #(.N(4), .C(4), .GALOIS(1'b1)) dut_g (.clk(clk), .rst_n(rst_n), .bus(ifg));
  frog_bank #(.N(4), .C(3), .GALOIS(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [1:0] ch;
    logic       v;
    logic       b;
    logic       run;
    logic       exp_busy;
    logic       exp_out0;
    logic [3:0] exp_lock;
    logic [3:0] exp_lfsr;
    logic [3:0] exp_taps;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic st, input logic [1:0] ch, input logic v, input logic b,
                              input logic run, input logic busy, input logic out0,
                              input logic [3:0] lk, input logic [3:0] lf, input logic [3:0] tp);
    vec_t r;
    r.st = st; r.ch = ch; r.v = v; r.b = b; r.run = run;
    r.exp_busy = busy; r.exp_out0 = out0; r.exp_lock = lk; r.exp_lfsr = lf; r.exp_taps = tp;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int sel, input logic st, input logic [1:0] ch, input logic v,
                     input logic b, input logic run);
    ifa.cfg_start = 1'b0; ifa.cfg_ch = '0; ifa.cfg_bit_valid = 1'b0; ifa.cfg_bit = 1'b0; ifa.run_en = 1'b0;
    ifg.cfg_start = 1'b0; ifg.cfg_ch = '0; ifg.cfg_bit_valid = 1'b0; ifg.cfg_bit = 1'b0; ifg.run_en = 1'b0;
    ifc.cfg_start = 1'b0; ifc.cfg_ch = '0; ifc.cfg_bit_valid = 1'b0; ifc.cfg_bit = 1'b0; ifc.run_en = 1'b0;
    case (sel)
      0: begin ifa.cfg_start = st; ifa.cfg_ch = ch; ifa.cfg_bit_valid = v; ifa.cfg_bit = b; ifa.run_en = run; end
      1: begin ifg.cfg_start = st; ifg.cfg_ch = ch; ifg.cfg_bit_valid = v; ifg.cfg_bit = b; ifg.run_en = run; end
      default: begin ifc.cfg_start = st; ifc.cfg_ch = ch; ifc.cfg_bit_valid = v; ifc.cfg_bit = b; ifc.run_en = run; end
    endcase
  endtask

  task automatic rd(input int sel, input logic [1:0] ch, output logic [3:0] l, output logic [3:0] t);
    case (sel)
      0: begin ifa.rd_ch = ch; #1; l = ifa.rd_lfsr; t = ifa.rd_taps; end
      1: begin ifg.rd_ch = ch; #1; l = ifg.rd_lfsr; t = ifg.rd_taps; end
      default: begin ifc.rd_ch = ch; #1; l = ifc.rd_lfsr; t = ifc.rd_taps; end
    endcase
  endtask

  task automatic load(input int sel, input logic [1:0] ch, input logic [3:0] taps, input logic [3:0] seed);
    drv(sel, 1'b1, ch, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin drv(sel, 1'b0, 2'd0, 1'b1, taps[i], 1'b0); tick(); end
    for (int i = 0; i < 4; i++) begin drv(sel, 1'b0, 2'd0, 1'b1, seed[i], 1'b0); tick(); end
    drv(sel, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drv(0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] l, t, l0, l1, l3;
    logic [3:0] gexp [4];
    int steps;
    logic seen_zero;

    n_vec = 0;
    n_bad = 0;
    ifa.rd_ch = '0; ifg.rd_ch = '0; ifc.rd_ch = '0;
    drv(0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;

    //               st ch  v  b  run  busy out0 lock     lfsr     taps
    tbl[0]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    tbl[1]  = mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    tbl[2]  = mk(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1000);
    tbl[3]  = mk(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1100);
    tbl[4]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0110);
    tbl[5]  = mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0110);
    tbl[6]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0011);
    tbl[7]  = mk(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000, 4'b0011);
    tbl[8]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0011);
    tbl[9]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010, 4'b0011);
    tbl[10] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 4'b0011);
    tbl[11] = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0001, 4'b0011);
    tbl[12] = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1110, 4'b1000, 4'b0011);
    tbl[13] = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1110, 4'b0100, 4'b0011);
    tbl[14] = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1110, 4'b0010, 4'b0011);
    tbl[15] = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1110, 4'b1001, 4'b0011);

    check("reset_err", 32'(ifa.cfg_err), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drv(0, tbl[i].st, tbl[i].ch, tbl[i].v, tbl[i].b, tbl[i].run);
      tick();
      check($sformatf("v%0d_busy", i), 32'(ifa.cfg_busy), 32'(tbl[i].exp_busy));
      check($sformatf("v%0d_out0", i), 32'(ifa.out[0]), 32'(tbl[i].exp_out0));
      check($sformatf("v%0d_lock", i), 32'(ifa.lockup), 32'(tbl[i].exp_lock));
      check($sformatf("v%0d_lfsr", i), 32'(ifa.rd_lfsr), 32'(tbl[i].exp_lfsr));
      check($sformatf("v%0d_taps", i), 32'(ifa.rd_taps), 32'(tbl[i].exp_taps));
    end

    // Fibonacci period: 4 steps done, keep stepping until seed returns
    steps = 4;
    drv(0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    while (ifa.rd_lfsr != 4'b0001 && steps < 40) begin
      tick();
      steps++;
    end
    check("fib_period", 32'(steps), 32'd15);
    check("fib_lock0", 32'(ifa.lockup[0]), 32'd0);

    // cfg_start in RUN: no step that cycle, channels hold through LOAD
    drv(0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();
    check("run_start_busy", 32'(ifa.cfg_busy), 32'd1);
    check("run_start_nostep", 32'(ifa.rd_lfsr), 32'h1);
    for (int i = 0; i < 8; i++) begin
      drv(0, 1'b0, 2'd0, 1'b1, (i == 0 || i == 1 || i == 4) ? 1'b1 : 1'b0, 1'b1);
      tick();
    end
    check("load1_busy", 32'(ifa.cfg_busy), 32'd0);
    check("load1_hold0", 32'(ifa.rd_lfsr), 32'h1);
    check("load1_lock", 32'(ifa.lockup), 32'b1100);
    drv(0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("rerun_enter", 32'(ifa.rd_lfsr), 32'h1);
    tick();
    check("rerun_step", 32'(ifa.rd_lfsr), 32'h8);
    drv(0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("run_off_hold", 32'(ifa.rd_lfsr), 32'h8);
    drv(0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("run_on_enter", 32'(ifa.rd_lfsr), 32'h8);
    tick();
    check("run_on_step", 32'(ifa.rd_lfsr), 32'h4);
    rd(0, 2'd1, l, t);
    check("ch1_taps", 32'(t), 32'b0011);
    check("ch1_state", 32'(l), 32'b0100);

    // reset in the middle of a load
    do_reset();
    drv(0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rd(0, 2'd0, l, t);
    drv(0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drv(0, 1'b0, 2'd0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      tick();
    end
    check("part_busy", 32'(ifa.cfg_busy), 32'd1);
    check("part_lfsr", 32'(ifa.rd_lfsr), 32'b1000);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(ifa.cfg_busy), 32'd0);
    check("rst_taps", 32'(ifa.rd_taps), 32'd0);
    check("rst_lfsr", 32'(ifa.rd_lfsr), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    drv(0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("post_rst_idle_busy", 32'(ifa.cfg_busy), 32'd0);
    check("post_rst_idle_taps", 32'(ifa.rd_taps), 32'd0);

    // load ch2 only and run ten steps
    load(0, 2'd2, 4'b0011, 4'b0001);
    drv(0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    rd(0, 2'd0, l, t);
`ifdef LOCKUP_RECOVER_EN
    check("ch0_first_step", 32'(l), 32'b0001);
`else
    check("ch0_first_step", 32'(l), 32'b0000);
`endif
    for (int i = 0; i < 9; i++) tick();
    drv(0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("only2_lock", 32'(ifa.lockup), 32'b1011);
    rd(0, 2'd2, l, t);
    check("only2_ch2", 32'(l), 32'b1101);
    rd(0, 2'd0, l0, t);
    rd(0, 2'd1, l1, t);
    rd(0, 2'd3, l3, t);
    check("only2_others", 32'({l0, l1, l3}), 32'd0);

    // Galois instance
    do_reset();
    load(1, 2'd0, 4'b1100, 4'b0001);
    check("gal_taps", 32'(ifg.rd_taps), 32'b1100);
    check("gal_seed", 32'(ifg.rd_lfsr), 32'b0001);
    gexp[0] = 4'b1100; gexp[1] = 4'b0110; gexp[2] = 4'b0011; gexp[3] = 4'b1101;
    drv(1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("gal_s%0d", i + 1), 32'(ifg.rd_lfsr), 32'(gexp[i]));
    end
    steps = 4;
    seen_zero = 1'b0;
    while (ifg.rd_lfsr != 4'b0001 && steps < 40) begin
      tick();
      steps++;
      if (ifg.rd_lfsr == 4'b0000) seen_zero = 1'b1;
    end
    drv(1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("gal_period", 32'(steps), 32'd15);
    check("gal_nonzero", 32'(seen_zero), 32'd0);
    check("gal_lock", 32'(ifg.lockup), 32'b1110);

    // out-of-range channel on the C=3 instance
    do_reset();
    check("c3_reset_err", 32'(ifc.cfg_err), 32'd0);
    drv(2, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
    tick();
    check("c3_err_pulse", 32'(ifc.cfg_err), 32'd1);
    check("c3_err_busy", 32'(ifc.cfg_busy), 32'd0);
    drv(2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("c3_err_clear", 32'(ifc.cfg_err), 32'd0);
    rd(2, 2'd3, l, t);
    check("c3_rd_oob", 32'({l, t}), 32'd0);
    drv(2, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    check("c3_ok_err", 32'(ifc.cfg_err), 32'd0);
    check("c3_ok_busy", 32'(ifc.cfg_busy), 32'd1);
    drv(2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
